// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of the shared ALU arbiter: request handshake with packed
// per-requester operands, and the one-entry response buffer handshake.
interface alu_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;

  // Requester side
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// The winner's operands drive the ALU; the result lands in a one-entry
// response buffer that is released by its owner's rsp_ready. A drain and a
// new accept can share a cycle, giving one result per cycle back to back.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic [3:0]           alu_con,
  input  logic [W-1:0]         alu_out
);

  // One-hot decode of a requester id.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] rsp_id_r;
  logic [W-1:0]   rsp_data_r;
  logic           full_r;

  logic [IDW-1:0] win_s;
  logic [IDW-1:0] scan_id_s;
  logic           found_s;
  logic           drain_s;
  logic           can_accept_s;
  logic           hs_s;
  logic [IDW-1:0] ptr_next_s;

  // Round-robin scan starting at ptr, wrapping modulo NREQ; first valid wins.
  always_comb begin
    found_s   = 1'b0;
    win_s     = '0;
    scan_id_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_id_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && bus.req_valid[scan_id_s]) begin
        found_s = 1'b1;
        win_s   = scan_id_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Buffer release / accept decisions and the pointer advance value.
  always_comb begin
    drain_s      = full_r && bus.rsp_ready[rsp_id_r];
    can_accept_s = !full_r || drain_s;
    hs_s         = found_s && can_accept_s;
    if (win_s == IDW'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_s + IDW'(1);
    end
  end

  // Grant and ALU operand drive from the winner; idle drives zeros.
  always_comb begin
    bus.req_ready = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_con       = 4'd0;
    if (found_s) begin
      alu_a   = bus.req_a[int'(win_s)*W +: W];
      alu_b   = bus.req_b[int'(win_s)*W +: W];
      alu_con = bus.req_op[int'(win_s)*4 +: 4];
      if (can_accept_s) begin
        bus.req_ready = onehot(win_s);
      end else begin
        bus.req_ready = '0;
      end
    end else begin
      bus.req_ready = '0;
    end
  end

  // Response outputs come straight from the buffer registers.
  always_comb begin
    bus.rsp_data = rsp_data_r;
    if (full_r) begin
      bus.rsp_valid = onehot(rsp_id_r);
    end else begin
      bus.rsp_valid = '0;
    end
  end

  // Response buffer and round-robin pointer; a new accept overrides a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r     <= 1'b0;
      rsp_id_r   <= '0;
      rsp_data_r <= '0;
      ptr_r      <= '0;
    end else if (hs_s) begin
      full_r     <= 1'b1;
      rsp_id_r   <= win_s;
      rsp_data_r <= alu_out;
      ptr_r      <= ptr_next_s;
    end else if (drain_s) begin
      full_r     <= 1'b0;
    end else begin
      full_r     <= full_r;
    end
  end

endmodule
